// File: rtl/spike_rate_meter_if.sv
// ============================================================================
// Module      : spike_rate_meter_if
// Description : Measurement controls and rate/ISI result strobes exchanged
//               between a spike source/host and spike_rate_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spike_rate_meter_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    parameter int ISI_W = 16
);
    logic             en;
    logic             spike;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] rate;
    logic             rate_sat;
    logic             rate_valid;
    logic [ISI_W-1:0] isi;
    logic             isi_valid;

    modport master (
        output en, spike, window_len,
        input  rate, rate_sat, rate_valid, isi, isi_valid
    );

    modport slave (
        input  en, spike, window_len,
        output rate, rate_sat, rate_valid, isi, isi_valid
    );
endinterface

`default_nettype wire

// File: rtl/spike_rate_meter.sv
// ============================================================================
// Module      : spike_rate_meter
// Description : Windowed spike-count (rate) and inter-spike-interval meter
//               with registered one-cycle result strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_rate_meter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    parameter int ISI_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spike_rate_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [ISI_W-1:0] C_ISI_MAX = '1;
    localparam logic [WIN_W-1:0] C_WIN_ONE = WIN_W'(1);

    logic [WIN_W-1:0] r_len;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_acc;
    logic             r_sticky;
    logic [ISI_W-1:0] r_icnt;
    logic             r_seen;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_sat;
    logic             r_rate_valid;
    logic [ISI_W-1:0] r_isi;
    logic             r_isi_valid;

    logic [WIN_W-1:0] w_len;
    logic             w_win_last;
    logic [CNT_W-1:0] w_acc_next;
    logic             w_sticky_next;

    // At window start the fresh length is used directly, so a 1-cycle window
    // closes in the same cycle its length is latched.
    always_comb begin
        w_len = r_len;
        if (r_win_cnt == '0) begin
            w_len = (bus.window_len == '0) ? C_WIN_ONE : bus.window_len;
        end
        w_win_last    = (r_win_cnt == (w_len - C_WIN_ONE));
        w_acc_next    = r_acc;
        if (bus.spike && (r_acc != C_CNT_MAX)) begin
            w_acc_next = r_acc + CNT_W'(1);
        end
        w_sticky_next = r_sticky | (w_acc_next == C_CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= '0;
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_sticky     <= 1'b0;
            r_icnt       <= '0;
            r_seen       <= 1'b0;
            r_rate       <= '0;
            r_rate_sat   <= 1'b0;
            r_rate_valid <= 1'b0;
            r_isi        <= '0;
            r_isi_valid  <= 1'b0;
        end else begin
            r_rate_valid <= 1'b0;
            r_isi_valid  <= 1'b0;
            if (bus.en) begin
                if (r_win_cnt == '0) begin
                    r_len <= w_len;
                end
                if (w_win_last) begin
                    r_rate       <= w_acc_next;
                    r_rate_sat   <= w_sticky_next;
                    r_rate_valid <= 1'b1;
                    r_acc        <= '0;
                    r_sticky     <= 1'b0;
                    r_win_cnt    <= '0;
                end else begin
                    r_acc        <= w_acc_next;
                    r_sticky     <= w_sticky_next;
                    r_win_cnt    <= r_win_cnt + C_WIN_ONE;
                end

                // The interval counter restarts at 1 so a spike on the very
                // next enabled cycle reports an ISI of 1.
                if (bus.spike) begin
                    r_icnt <= ISI_W'(1);
                    r_seen <= 1'b1;
                    if (r_seen) begin
                        r_isi       <= r_icnt;
                        r_isi_valid <= 1'b1;
                    end
                end else if (r_icnt != C_ISI_MAX) begin
                    r_icnt <= r_icnt + ISI_W'(1);
                end
            end
        end
    end

    assign bus.rate       = r_rate;
    assign bus.rate_sat   = r_rate_sat;
    assign bus.rate_valid = r_rate_valid;
    assign bus.isi        = r_isi;
    assign bus.isi_valid  = r_isi_valid;

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_meter.sv
// ============================================================================
// Module      : tb_spike_rate_meter
// Description : Scoreboard bench for spike_rate_meter against a model based on
//               enabled-cycle indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_rate_meter;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int ISI_W = 16;
    localparam longint MAXC = (64'd1 << CNT_W) - 1;
    localparam longint MAXI = (64'd1 << ISI_W) - 1;

    typedef struct {
        longint cyc;
        longint val;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spike_rate_meter_if #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ISI_W(ISI_W)) vif ();

    spike_rate_meter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ISI_W(ISI_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    exp_t   rq[$];
    exp_t   iq[$];
    longint exp_rate = 0;
    bit     exp_sat  = 0;
    longint exp_isi  = 0;

    // model: enabled-cycle index, window start/length, spike count, last spike index
    longint m_k, m_wstart, m_len, m_cnt, m_last;
    bit     m_seen;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (vif.rate_valid) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rate_unexpected: got strobe expected none (cycle %0d)", cyc);
            end else begin
                e = rq.pop_front();
                chk("rate_time", cyc, e.cyc);
                exp_rate = e.val;
                exp_sat  = e.sat;
            end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
            total++; bad++;
            $display("FAIL rate_missing: got no strobe expected one at cycle %0d", rq[0].cyc);
            void'(rq.pop_front());
        end
        if (vif.isi_valid) begin
            if (iq.size() == 0) begin
                total++; bad++;
                $display("FAIL isi_unexpected: got strobe expected none (cycle %0d)", cyc);
            end else begin
                e = iq.pop_front();
                chk("isi_time", cyc, e.cyc);
                exp_isi = e.val;
            end
        end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
            total++; bad++;
            $display("FAIL isi_missing: got no strobe expected one at cycle %0d", iq[0].cyc);
            void'(iq.pop_front());
        end
        chk("rate", longint'(vif.rate), exp_rate);
        chk("rate_sat", longint'(vif.rate_sat), longint'(exp_sat));
        chk("isi", longint'(vif.isi), exp_isi);
    end

    task automatic model_clear();
        m_k = 0; m_wstart = 0; m_len = 1; m_cnt = 0; m_last = 0; m_seen = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vif.en = 1'b0;
        vif.spike = 1'b0;
        @(posedge clk); #1;
        model_clear();
        rq.delete(); iq.delete();
        exp_rate = 0; exp_sat = 0; exp_isi = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step(input bit e, input bit s);
        exp_t x;
        vif.en = e;
        vif.spike = s;
        if (e) begin
            if (m_k == m_wstart) m_len = (vif.window_len == 0) ? 1 : longint'(vif.window_len);
            if (s) m_cnt++;
            if (m_k == m_wstart + m_len - 1) begin
                x.cyc = cyc + 1;
                x.val = (m_cnt > MAXC) ? MAXC : m_cnt;
                x.sat = (m_cnt >= MAXC);
                rq.push_back(x);
                m_cnt = 0;
                m_wstart = m_k + 1;
            end
            if (s) begin
                if (m_seen) begin
                    x.cyc = cyc + 1;
                    x.val = (m_k - m_last > MAXI) ? MAXI : (m_k - m_last);
                    x.sat = 0;
                    iq.push_back(x);
                end
                m_seen = 1;
                m_last = m_k;
            end
            m_k++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vif.en = 1'b0;
        vif.spike = 1'b0;
        vif.window_len = 16'd10;
        model_clear();
        do_reset();
        chk("reset_rate_valid", longint'(vif.rate_valid), 0);
        chk("reset_isi_valid", longint'(vif.isi_valid), 0);

        // spike every third cycle, 10-cycle windows
        for (int i = 0; i < 60; i++) step(1'b1, (i % 3) == 0);

        // randomized mix of enable, spikes and window lengths (including 0)
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) vif.window_len = 16'($urandom_range(0, 20));
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30);
        end

        // saturation then an empty window
        do_reset();
        vif.window_len = 16'd300;
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0);

        // spikes at 5, 12, 13 then a very long interval
        do_reset();
        vif.window_len = 16'd1000;
        for (int i = 0; i < 14; i++) step(1'b1, (i == 5) || (i == 12) || (i == 13));
        for (int i = 0; i < 70000; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // disabled gap inside a window and between spikes
        do_reset();
        vif.window_len = 16'd10;
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

        // length change mid-window, then reset mid-window
        do_reset();
        vif.window_len = 16'd10;
        for (int i = 0; i < 3; i++) step(1'b1, i == 1);
        vif.window_len = 16'd5;
        for (int i = 0; i < 20; i++) step(1'b1, (i % 4) == 0);
        do_reset();
        chk("rst_rate", longint'(vif.rate), 0);
        chk("rst_isi", longint'(vif.isi), 0);
        for (int i = 0; i < 12; i++) step(1'b1, i == 2);

        vif.en = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        chk("rate_queue_drained", rq.size(), 0);
        chk("isi_queue_drained", iq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
